// File: rtl/cordic_fixedpoint_pkg.sv
// Shared definitions for the iterative CORDIC rotation engine.
//   - Default iteration count and datapath width.
//   - CORDIC gain constant K in Q2.21.
//   - FSM state type.
//   - Bit positions inside the octant-correction info code.
package cordic_fixedpoint_pkg;

    localparam int unsigned ITER_DEFAULT = 20;
    localparam int unsigned DW_DEFAULT   = 24;

    // 0.6072529 in Q2.21. Preloading X with K cancels the rotation gain.
    localparam logic [23:0] K_GAIN = 24'h136E9E;

    // Info code bit positions. Bit 3 is ignored.
    localparam int unsigned SWAP    = 0;
    localparam int unsigned NEG_COS = 1;
    localparam int unsigned NEG_SIN = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRot,
        StOut
    } cordic_state_e;

endpackage

// File: rtl/cordic_fixedpoint_rotate_atan_rom.sv
// Combinational arctangent table for the CORDIC micro-rotations.
// Ports:
//   iIndex  in  5   iteration index i
//   oAtan   out DW  round(atan(2^-i) * 2^21); zero for i > 21
module cordic_fixedpoint_rotate_atan_rom #(
    parameter int unsigned DW = 24
) (
    input  logic [4:0]    iIndex,
    output logic [DW-1:0] oAtan
);

    logic [23:0] atan_val;

    always_comb begin
        atan_val = '0;
        case (iIndex)
            5'd0:    atan_val = 24'h1921FB;
            5'd1:    atan_val = 24'h0ED634;
            5'd2:    atan_val = 24'h07D6DD;
            5'd3:    atan_val = 24'h03FAB7;
            5'd4:    atan_val = 24'h01FF56;
            5'd5:    atan_val = 24'h00FFEB;
            5'd6:    atan_val = 24'h007FFD;
            5'd7:    atan_val = 24'h004000;
            5'd8:    atan_val = 24'h002000;
            5'd9:    atan_val = 24'h001000;
            5'd10:   atan_val = 24'h000800;
            5'd11:   atan_val = 24'h000400;
            5'd12:   atan_val = 24'h000200;
            5'd13:   atan_val = 24'h000100;
            5'd14:   atan_val = 24'h000080;
            5'd15:   atan_val = 24'h000040;
            5'd16:   atan_val = 24'h000020;
            5'd17:   atan_val = 24'h000010;
            5'd18:   atan_val = 24'h000008;
            5'd19:   atan_val = 24'h000004;
            5'd20:   atan_val = 24'h000002;
            5'd21:   atan_val = 24'h000001;
            default: atan_val = '0;
        endcase
    end

    assign oAtan = DW'(atan_val);

endmodule

// File: rtl/cordic_fixedpoint_rotate_iter.sv
// Iterative CORDIC rotation engine. Takes a first-octant phase plus an
// octant-correction code, performs ITER shift-add micro-rotations (one per
// clock), then applies swap/negate correction to produce full-range sin/cos.
// Ports:
//   iClk                   in   1   clock, rising edge
//   iReset_n               in   1   synchronous active-low reset
//   iPhase_valid           in   1   input sample strobe
//   iPhase_normalize       in   22  unsigned Q1.21 phase, 0..pi/4
//   iPhase_normalize_info  in   4   [0] swap, [1] negate cos, [2] negate sin
//   oReady                 out  1   idle, strobe will be accepted
//   oOverrun               out  1   pulse: strobe dropped while busy
//   oSinCos_valid          out  1   pulse: oSine/oCosine updated
//   oSine, oCosine         out  DW  signed Q2.21 results, held between updates
module cordic_fixedpoint_rotate_iter
    import cordic_fixedpoint_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEFAULT,
    parameter int unsigned DW   = DW_DEFAULT
) (
    input  logic          iClk,
    input  logic          iReset_n,
    input  logic          iPhase_valid,
    input  logic [21:0]   iPhase_normalize,
    input  logic [3:0]    iPhase_normalize_info,
    output logic          oReady,
    output logic          oOverrun,
    output logic          oSinCos_valid,
    output logic [DW-1:0] oSine,
    output logic [DW-1:0] oCosine
);

    cordic_state_e state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [2:0]    info_q, info_d;

    logic signed [DW-1:0] x_q, x_d;
    logic signed [DW-1:0] y_q, y_d;
    logic signed [DW-1:0] z_q, z_d;
    logic signed [DW-1:0] sine_q, sine_d;
    logic signed [DW-1:0] cosine_q, cosine_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    logic [DW-1:0]        atan_raw;
    logic signed [DW-1:0] atan_val;
    logic signed [DW-1:0] x_shift;
    logic signed [DW-1:0] y_shift;
    logic signed [DW-1:0] cos_sel;
    logic signed [DW-1:0] sin_sel;
    logic                 z_neg;
    logic                 unused_info;

    // Bit 3 of the info code carries no meaning here.
    assign unused_info = iPhase_normalize_info[3];

    cordic_fixedpoint_rotate_atan_rom #(
        .DW (DW)
    ) u_atan_rom (
        .iIndex (cnt_q),
        .oAtan  (atan_raw)
    );

    assign atan_val = atan_raw;
    assign x_shift  = x_q >>> cnt_q;
    assign y_shift  = y_q >>> cnt_q;
    assign z_neg    = z_q[DW-1];

    // X converges to cos and Y to sin of the folded phase; swap if requested.
    assign cos_sel = info_q[SWAP] ? y_q : x_q;
    assign sin_sel = info_q[SWAP] ? x_q : y_q;

    assign oReady        = (state_q == StIdle);
    assign oOverrun      = overrun_q;
    assign oSinCos_valid = valid_q;
    assign oSine         = sine_q;
    assign oCosine       = cosine_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        info_d    = info_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        sine_d    = sine_q;
        cosine_d  = cosine_q;
        valid_d   = 1'b0;
        // Upstream cannot stall: a strobe while busy is dropped and flagged.
        overrun_d = iPhase_valid && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (iPhase_valid) begin
                    state_d = StRot;
                    cnt_d   = '0;
                    info_d  = iPhase_normalize_info[2:0];
                    x_d     = DW'(K_GAIN);
                    y_d     = '0;
                    z_d     = DW'(iPhase_normalize);
                end
            end
            StRot: begin
                if (z_neg) begin
                    x_d = x_q + y_shift;
                    y_d = y_q - x_shift;
                    z_d = z_q + atan_val;
                end else begin
                    x_d = x_q - y_shift;
                    y_d = y_q + x_shift;
                    z_d = z_q - atan_val;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER - 1)) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                cosine_d = info_q[NEG_COS] ? -cos_sel : cos_sel;
                sine_d   = info_q[NEG_SIN] ? -sin_sel : sin_sel;
                valid_d  = 1'b1;
                cnt_d    = '0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            info_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            sine_q    <= '0;
            cosine_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            info_q    <= info_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            sine_q    <= sine_d;
            cosine_q  <= cosine_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_cordic_fixedpoint_rotate_iter.sv
// Bench for cordic_fixedpoint_rotate_iter: directed corner cases plus random
// phases, checked against real-valued sin/cos of the reconstructed angle.
module tb_cordic_fixedpoint_rotate_iter;

    localparam int LAT = 22;
    localparam int TOL = 8;

    logic        iClk = 1'b0;
    logic        iReset_n;
    logic        iPhase_valid;
    logic [21:0] iPhase_normalize;
    logic [3:0]  iPhase_normalize_info;
    logic        oReady;
    logic        oOverrun;
    logic        oSinCos_valid;
    logic [23:0] oSine;
    logic [23:0] oCosine;

    int total = 0;
    int bad   = 0;

    cordic_fixedpoint_rotate_iter dut (
        .iClk                  (iClk),
        .iReset_n              (iReset_n),
        .iPhase_valid          (iPhase_valid),
        .iPhase_normalize      (iPhase_normalize),
        .iPhase_normalize_info (iPhase_normalize_info),
        .oReady                (oReady),
        .oOverrun              (oOverrun),
        .oSinCos_valid         (oSinCos_valid),
        .oSine                 (oSine),
        .oCosine               (oCosine)
    );

    always #5 iClk = ~iClk;

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic [23:0] obs, input int exp);
        int o;
        int diff;
        o    = int'($signed(obs));
        diff = o - exp;
        total++;
        assert (diff <= TOL && diff >= -TOL) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, exp);
        end
    endtask

    // Reference: full-range cos/sin of the phase after octant correction.
    task automatic model(input logic [21:0] phase, input logic [3:0] info,
                         output int exp_cos, output int exp_sin);
        real p, c0, s0, c, s;
        p  = real'(phase) / 2097152.0;
        c0 = $cos(p);
        s0 = $sin(p);
        c  = info[0] ? s0 : c0;
        s  = info[0] ? c0 : s0;
        if (info[1]) c = -c;
        if (info[2]) s = -s;
        exp_cos = rnd(c * 2097152.0);
        exp_sin = rnd(s * 2097152.0);
    endtask

    task automatic strobe(input logic [21:0] phase, input logic [3:0] info);
        @(negedge iClk);
        iPhase_valid          = 1'b1;
        iPhase_normalize      = phase;
        iPhase_normalize_info = info;
    endtask

    // Wait for oSinCos_valid, expecting it after exp_lat negedges. With chain
    // set, a new strobe is driven in the very cycle the result is valid.
    task automatic wait_result(input string tag, input logic [21:0] phase,
                               input logic [3:0] info, input int exp_lat,
                               input bit chain, input logic [21:0] nphase,
                               input logic [3:0] ninfo);
        int n;
        bit got;
        int ec, es;
        n   = 0;
        got = 1'b0;
        model(phase, info, ec, es);
        for (int k = 0; k < 60; k++) begin
            @(negedge iClk);
            iPhase_valid = 1'b0;
            n++;
            if (oSinCos_valid) begin
                got = 1'b1;
                break;
            end
        end
        check_eq({tag, "_seen"}, int'(got), 1);
        if (got) begin
            check_eq({tag, "_latency"}, n, exp_lat);
            check_tol({tag, "_cos"}, oCosine, ec);
            check_tol({tag, "_sin"}, oSine, es);
            check_eq({tag, "_ready"}, int'(oReady), 1);
        end
        if (chain) begin
            iPhase_valid          = 1'b1;
            iPhase_normalize      = nphase;
            iPhase_normalize_info = ninfo;
        end else begin
            @(negedge iClk);
            check_eq({tag, "_pulse_low"}, int'(oSinCos_valid), 0);
        end
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge iClk);
            iPhase_valid = 1'b0;
            if (oSinCos_valid) cnt++;
        end
    endtask

    initial begin
        int vcnt;
        logic [21:0] rp;
        logic [3:0]  ri;

        iReset_n              = 1'b0;
        iPhase_valid          = 1'b0;
        iPhase_normalize      = '0;
        iPhase_normalize_info = '0;
        repeat (3) @(negedge iClk);
        check_eq("rst_ready", int'(oReady), 1);
        check_eq("rst_overrun", int'(oOverrun), 0);
        check_eq("rst_valid", int'(oSinCos_valid), 0);
        check_eq("rst_sine", int'(oSine), 0);
        check_eq("rst_cosine", int'(oCosine), 0);
        iReset_n = 1'b1;

        // Directed corners.
        strobe(22'h000000, 4'h0);
        wait_result("zero", 22'h000000, 4'h0, LAT, 1'b0, '0, '0);
        strobe(22'h1921FB, 4'h0);
        wait_result("pi4", 22'h1921FB, 4'h0, LAT, 1'b0, '0, '0);
        strobe(22'h0C90FE, 4'b0101);
        wait_result("pi8_swap_negsin", 22'h0C90FE, 4'b0101, LAT, 1'b0, '0, '0);
        strobe(22'h0C90FE, 4'b1010);
        wait_result("pi8_negcos", 22'h0C90FE, 4'b1010, LAT, 1'b0, '0, '0);

        // Overrun: second strobe 5 cycles in is dropped.
        strobe(22'h0A0000, 4'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge iClk);
            iPhase_valid = 1'b0;
        end
        iPhase_valid          = 1'b1;
        iPhase_normalize      = 22'h150000;
        iPhase_normalize_info = 4'h7;
        @(negedge iClk);
        iPhase_valid = 1'b0;
        check_eq("ovr_pulse", int'(oOverrun), 1);
        @(negedge iClk);
        check_eq("ovr_pulse_low", int'(oOverrun), 0);
        wait_result("ovr_first", 22'h0A0000, 4'h0, LAT - 7, 1'b0, '0, '0);
        count_valid(30, vcnt);
        check_eq("ovr_no_extra_valid", vcnt, 0);

        // Back-to-back: strobe coincident with oSinCos_valid is accepted.
        strobe(22'h040000, 4'h2);
        wait_result("b2b_a", 22'h040000, 4'h2, LAT, 1'b1, 22'h123456, 4'h4);
        wait_result("b2b_b", 22'h123456, 4'h4, LAT, 1'b0, '0, '0);
        check_eq("b2b_no_overrun", int'(oOverrun), 0);

        // Reset during iteration ~10 discards the sample.
        strobe(22'h100000, 4'h1);
        for (int k = 0; k < 10; k++) begin
            @(negedge iClk);
            iPhase_valid = 1'b0;
        end
        iReset_n = 1'b0;
        @(negedge iClk);
        check_eq("mid_rst_ready", int'(oReady), 1);
        check_eq("mid_rst_sine", int'(oSine), 0);
        check_eq("mid_rst_cosine", int'(oCosine), 0);
        check_eq("mid_rst_valid", int'(oSinCos_valid), 0);
        iReset_n = 1'b1;
        count_valid(30, vcnt);
        check_eq("mid_rst_no_valid", vcnt, 0);
        strobe(22'h100000, 4'h1);
        wait_result("post_rst", 22'h100000, 4'h1, LAT, 1'b0, '0, '0);

        // Random phases and correction codes.
        for (int t = 0; t < 10; t++) begin
            rp = 22'($urandom_range(32'h1921FB, 0));
            ri = 4'($urandom_range(15, 0));
            strobe(rp, ri);
            wait_result("rand", rp, ri, LAT, 1'b0, '0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_fixedpoint_rotate_iter.md
# cordic_fixedpoint_rotate_iter

Iterative CORDIC rotation engine that sits directly downstream of the angle-normalisation stage. It accepts a phase already folded into the first octant [0, π/4] plus a 4-bit octant-correction code, and runs a fixed number of shift-add micro-rotations, one per clock. It then applies the swap/sign correction and emits full-range sine and cosine. It is multi-cycle and non-pipelined, with a ready/valid handshake and overrun flagging, because the upstream stage cannot stall.

## Interface
- ITER, 20, number of micro-rotations (legal 16..22)
- DW, 24, internal/output datapath width, signed Q2.21
- iClk  in  1  clock, all logic on rising edge
- iReset_n  in  1  reset, synchronous, active-low
- iPhase_valid  in  1  input sample strobe
- iPhase_normalize  in  22  unsigned Q1.21 radians, range 0..0x1921FB (π/4)
- iPhase_normalize_info  in  4  [0] swap sin/cos, [1] negate cosine, [2] negate sine, [3] ignored
- oReady  out  1  high when idle and able to accept
- oOverrun  out  1  one-cycle pulse: strobe arrived while busy and was dropped
- oSinCos_valid  out  1  one-cycle pulse: results updated
- oSine  out  DW  signed Q2.21
- oCosine  out  DW  signed Q2.21

## Operation
- FSM states: IDLE, ROT, OUT.
- IDLE
  - oReady=1.
  - On iPhase_valid, load registers and go to ROT:
    - X=K=0x136E9E (0.6072529 in Q2.21), Y=0.
    - Z = zero-extended phase.
    - info register = iPhase_normalize_info.
    - iteration counter i=0.
- ROT, each cycle:
  - d=+1 if Z≥0 (sign bit clear), else −1.
  - X ← X − d·(Y>>>i).
  - Y ← Y + d·(X>>>i).
  - Z ← Z − d·atan(2^-i).
  - All arithmetic is DW-bit two's complement with arithmetic shifts; overflow is impossible by range.
  - i increments each cycle; after iteration ITER−1, go to OUT.
- OUT, single cycle:
  - c = info[0] ? Y : X; s = info[0] ? X : Y.
  - oCosine ← info[1] ? −c : c; oSine ← info[2] ? −s : s.
  - oSinCos_valid ← 1; state ← IDLE.
- Sample accounting:
  - iPhase_valid while oReady=0 drops the sample and pulses oOverrun next cycle.
  - It has no effect on the computation in flight.
- oSine and oCosine hold their last value until the next OUT.
- atan table: entry i = round(atan(2^-i)·2^21), DW bits; entry 0 = 0x1921FB.
- Accuracy: |error| ≤ 8 LSB on both outputs for ITER=20.

## Timing
- Reset values: oReady=1, oOverrun=0, oSinCos_valid=0, oSine=0, oCosine=0; FSM=IDLE, counter=0.
- Latency: sample accepted at edge T; ITER rotation edges T+1..T+ITER; OUT edge T+ITER+1.
- oSinCos_valid is high during the cycle after edge T+ITER+1 (22 cycles after acceptance for ITER=20).
- oReady is combinational from state. It is high in the same cycle oSinCos_valid is high, so a strobe coincident with oSinCos_valid is accepted.
- Maximum throughput is one sample per ITER+2 cycles.
- Reset mid-operation: at the next edge, return to IDLE, clear all outputs to reset values, and discard the in-flight sample; no oSinCos_valid.
- oOverrun and oSinCos_valid are never held longer than one cycle.

## Structure
- Shared package cordic_fixedpoint_pkg holds:
  - ITER and DW defaults.
  - CORDIC gain constant K (0x136E9E).
  - FSM state typedef.
  - Info-bit index constants (SWAP=0, NEG_COS=1, NEG_SIN=2).
- Sub-module cordic_fixedpoint_rotate_atan_rom: combinational, 5-bit index in, DW-bit atan(2^-i) out, entries 0..21 constant, others 0.
- Top contains the FSM, the iteration counter, the X/Y/Z registers with shift-add datapath, and the output correction.

## Test plan
- Phase 0x000000, info 0 → after 22 cycles, oCosine≈0x200000, oSine≈0 (±8 LSB); single oSinCos_valid pulse.
- Phase 0x1921FB, info 0 → oSine≈oCosine≈0x16A09E (±8 LSB).
- Phase 0x0C90FE (π/8), info 4'b0101 (swap, negate sine) → oCosine≈0x0C3EF1 (0.3827), oSine≈−0x1D906C (−0.9239).
- Second strobe 5 cycles after the first → dropped, oOverrun pulses once, exactly one oSinCos_valid, first result unchanged.
- Strobe coincident with the first oSinCos_valid → accepted; second oSinCos_valid exactly 22 cycles after the first.
- iReset_n low for one cycle at iteration 10 → outputs 0, oReady=1 the next cycle, no oSinCos_valid; a new sample then completes normally.
